// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: gates PC updates on icache hit and pipeline stall,
// holds a redirect target across stalls and parks in HALTED until reset.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   RUN    | normal sequential fetch, redirects applied when not stalled
//   PEND   | redirect arrived under stall; target held in pend_pc_q
//   HALTED | halt committed; no fetches until RST
module fetch_ctrl #(
   parameter int PC_W = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [PC_W-1:0] curr_pc,
   input  logic [PC_W-1:0] npc,
   input  logic            ihit,
   input  logic            stall,
   input  logic            redirect_en,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            halt,
   output logic            pc_en,
   output logic [PC_W-1:0] new_pc,
   output logic            imemREN,
   output logic [PC_W-1:0] imemaddr,
   output logic            fetch_valid,
   output logic            halted,
   output logic [31:0]     fetch_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      PEND   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
   logic [31:0]       fetch_cnt_q, fetch_cnt_d;

   always_comb begin
      state_d     = state_q;
      pend_pc_d   = pend_pc_q;
      pc_en       = 1'b0;
      new_pc      = npc;
      fetch_valid = 1'b0;
      imemREN     = 1'b0;
      imemaddr    = curr_pc;

      if (!RST) begin
         case (state_q)
            RUN: begin
               imemREN = 1'b1;
               if (halt) begin
                  state_d = HALTED;
               end else if (redirect_en) begin
                  if (!stall) begin
                     pc_en  = 1'b1;
                     new_pc = redirect_pc;
                  end else begin
                     pend_pc_d = redirect_pc;
                     state_d   = PEND;
                  end
               end else if (ihit && !stall) begin
                  pc_en       = 1'b1;
                  fetch_valid = 1'b1;
               end
            end
            PEND: begin
               imemREN = 1'b1;
               if (halt) begin
                  state_d = HALTED;
               end else if (!stall) begin
                  // A fresh redirect on the release cycle is younger than the held one.
                  pc_en   = 1'b1;
                  new_pc  = redirect_en ? redirect_pc : pend_pc_q;
                  state_d = RUN;
               end else if (redirect_en) begin
                  pend_pc_d = redirect_pc;
               end
            end
            HALTED: begin
               state_d = HALTED;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end

      fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_valid};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= RUN;
         pend_pc_q   <= '0;
         fetch_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pend_pc_q   <= pend_pc_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign halted    = (state_q == HALTED) && !RST;
   assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, misses, stalled redirects,
// halt priority and reset recovery, with hand-computed expectations.
module tb_fetch_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] curr_pc, npc, redirect_pc;
   logic        ihit, stall, redirect_en, halt;
   logic        pc_en, imemREN, fetch_valid, halted;
   logic [31:0] new_pc, imemaddr, fetch_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 CLK = ~CLK;

   fetch_ctrl #(.PC_W(32)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .curr_pc    (curr_pc),
      .npc        (npc),
      .ihit       (ihit),
      .stall      (stall),
      .redirect_en(redirect_en),
      .redirect_pc(redirect_pc),
      .halt       (halt),
      .pc_en      (pc_en),
      .new_pc     (new_pc),
      .imemREN    (imemREN),
      .imemaddr   (imemaddr),
      .fetch_valid(fetch_valid),
      .halted     (halted),
      .fetch_cnt  (fetch_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance one cycle; new inputs are applied 1 ns after the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic i_hit, input logic i_stall, input logic i_redir,
                        input logic [31:0] i_rpc, input logic i_halt);
      ihit        = i_hit;
      stall       = i_stall;
      redirect_en = i_redir;
      redirect_pc = i_rpc;
      halt        = i_halt;
      #1;
   endtask

   initial begin
      RST = 1'b1;
      curr_pc = 32'h100;
      npc     = 32'h104;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("rst_pc_en", pc_en, 0);
      check("rst_fv", fetch_valid, 0);
      check("rst_imemREN", imemREN, 0);
      check("rst_halted", halted, 0);
      tick();
      tick();
      RST = 1'b0;

      // sequential fetch
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
         check("seq_pc_en", pc_en, 1);
         check("seq_new_pc", new_pc, 32'h104);
         check("seq_fv", fetch_valid, 1);
         check("seq_imemaddr", imemaddr, 32'h100);
         check("seq_imemREN", imemREN, 1);
         tick();
      end
      check("seq_cnt", fetch_cnt, 3);

      // icache miss for 4 cycles
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
         check("miss_pc_en", pc_en, 0);
         check("miss_fv", fetch_valid, 0);
         check("miss_new_pc", new_pc, 32'h104);
         tick();
      end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("miss_end_pc_en", pc_en, 1);
      tick();
      check("miss_cnt", fetch_cnt, 4);

      // hit under stall is not accepted
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      check("stall_pc_en", pc_en, 0);
      check("stall_fv", fetch_valid, 0);
      tick();
      check("stall_cnt", fetch_cnt, 4);

      // unstalled redirect
      drive(1'b1, 1'b0, 1'b1, 32'h180, 1'b0);
      check("redir_pc_en", pc_en, 1);
      check("redir_new_pc", new_pc, 32'h180);
      check("redir_fv", fetch_valid, 0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("redir_run_fv", fetch_valid, 1);
      tick();
      check("redir_cnt", fetch_cnt, 5);

      // redirect under stall -> PEND
      drive(1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
      check("pend_in_pc_en", pc_en, 0);
      check("pend_in_fv", fetch_valid, 0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      check("pend_hold_pc_en", pc_en, 0);
      check("pend_imemREN", imemREN, 1);
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("pend_rel_pc_en", pc_en, 1);
      check("pend_rel_new_pc", new_pc, 32'h200);
      check("pend_rel_fv", fetch_valid, 0);
      tick();
      check("pend_cnt", fetch_cnt, 5);

      // overwrite of the held target
      drive(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b1, 32'h300, 1'b0);
      check("ovw_pc_en", pc_en, 0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("ovw_new_pc", new_pc, 32'h300);
      check("ovw_pc_en_rel", pc_en, 1);
      tick();

      // fresh redirect on the release cycle wins over the held one
      drive(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1, 32'h340, 1'b0);
      check("rel_redir_new_pc", new_pc, 32'h340);
      tick();

      // halt and redirect in the same cycle
      drive(1'b1, 1'b0, 1'b1, 32'h400, 1'b1);
      check("halt_pc_en", pc_en, 0);
      check("halt_fv", fetch_valid, 0);
      check("halt_new_pc", new_pc, 32'h104);
      tick();
      drive(1'b1, 1'b0, 1'b1, 32'h500, 1'b0);
      check("halted", halted, 1);
      check("halted_imemREN", imemREN, 0);
      check("halted_pc_en", pc_en, 0);
      check("halted_imemaddr", imemaddr, 32'h100);
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("halted_stay", halted, 1);
      check("halted_fv", fetch_valid, 0);
      tick();
      check("halted_cnt", fetch_cnt, 5);

      // reset out of HALTED
      RST = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("rst_h_halted", halted, 0);
      check("rst_h_imemREN", imemREN, 0);
      tick();
      RST = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("rst_h_after_halted", halted, 0);
      check("rst_h_cnt", fetch_cnt, 0);
      check("rst_h_imemREN1", imemREN, 1);
      check("rst_h_fv", fetch_valid, 1);
      tick();
      check("rst_h_cnt1", fetch_cnt, 1);

      // reset out of PEND
      drive(1'b1, 1'b1, 1'b1, 32'h600, 1'b0);
      tick();
      RST = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("rst_p_pc_en", pc_en, 0);
      tick();
      RST = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("rst_p_new_pc", new_pc, 32'h104);
      check("rst_p_fv", fetch_valid, 1);
      check("rst_p_cnt", fetch_cnt, 0);
      check("rst_p_imemREN", imemREN, 1);
      tick();

      // halt while PEND
      drive(1'b0, 1'b1, 1'b1, 32'h700, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("pend_halt_pc_en", pc_en, 0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("pend_halt_halted", halted, 1);
      check("pend_halt_cnt", fetch_cnt, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter: PC_W, 32, width of all address/PC buses (matches word_t).
REQ-002 SHALL have port: CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: curr_pc  input  PC_W  current PC value from the program counter.
REQ-005 SHALL have port: npc  input  PC_W  sequential next PC (curr_pc+4) from the program counter.
REQ-006 SHALL have port: ihit  input  1  instruction memory returned data for imemaddr this cycle.
REQ-007 SHALL have port: stall  input  1  pipeline cannot accept a new instruction this cycle.
REQ-008 SHALL have port: redirect_en  input  1  resolved branch/jump; fetch must restart at redirect_pc.
REQ-009 SHALL have port: redirect_pc  input  PC_W  redirect target address.
REQ-010 SHALL have port: halt  input  1  halt instruction committed.
REQ-011 SHALL have port: pc_en  output  1  PC write enable (drives program counter en).
REQ-012 SHALL have port: new_pc  output  PC_W  value written to PC when pc_en=1.
REQ-013 SHALL have port: imemREN  output  1  instruction fetch request.
REQ-014 SHALL have port: imemaddr  output  PC_W  fetch address.
REQ-015 SHALL have port: fetch_valid  output  1  fetched instruction is valid and accepted this cycle.
REQ-016 SHALL have port: halted  output  1  controller in HALTED state.
REQ-017 SHALL have port: fetch_cnt  output  32  count of accepted fetches.

Function
REQ-018 SHALL implement states RUN, PEND (redirect held), HALTED; pending register pend_pc (PC_W).
REQ-019 SHALL drive imemREN=1 and imemaddr=curr_pc in RUN and PEND; imemREN=0, imemaddr=curr_pc in HALTED.
REQ-020 SHALL, in RUN with redirect_en=0, assert pc_en=1, new_pc=npc, fetch_valid=1 exactly when ihit=1 and stall=0; else pc_en=0, fetch_valid=0.
REQ-021 SHALL, in RUN with redirect_en=1 and stall=0, assert pc_en=1, new_pc=redirect_pc, fetch_valid=0 regardless of ihit; stay RUN.
REQ-022 SHALL, in RUN with redirect_en=1 and stall=1, keep pc_en=0, fetch_valid=0, load pend_pc<=redirect_pc, go PEND next cycle.
REQ-023 SHALL, in PEND, hold fetch_valid=0; when stall=0 assert pc_en=1, new_pc=(redirect_en ? redirect_pc : pend_pc), go RUN.
REQ-024 SHALL, in PEND with stall=1 and redirect_en=1, overwrite pend_pc<=redirect_pc and stay PEND.
REQ-025 SHALL give halt priority over redirect and fetch: halt=1 in RUN or PEND forces pc_en=0, fetch_valid=0 that cycle and HALTED next cycle.
REQ-026 SHALL, in HALTED, hold pc_en=0, fetch_valid=0, halted=1, ignore all inputs except RST; only RST exits.
REQ-027 SHALL increment fetch_cnt by 1 on every cycle with fetch_valid=1, wrapping 0xFFFFFFFF->0.
REQ-028 SHALL combinationally derive pc_en, new_pc, fetch_valid, imemREN, imemaddr from state and inputs (zero-cycle latency); halted and fetch_cnt registered.
REQ-029 SHALL drive new_pc=npc whenever pc_en=0 (no X on output).

Reset
REQ-030 SHALL, while RST=1, force pc_en=0, fetch_valid=0, imemREN=0, halted=0; on the edge set state=RUN, pend_pc=0, fetch_cnt=0.
REQ-031 SHALL abandon any pending redirect or HALTED state on RST mid-operation; first cycle after RST deasserts is RUN with imemREN=1.

Verification
REQ-032 SHALL test sequential fetch: curr_pc=0x100, npc=0x104, ihit=1, stall=0 for 3 cycles -> pc_en=1, new_pc=0x104 each cycle, fetch_cnt=3.
REQ-033 SHALL test icache miss: ihit=0 for 4 cycles then 1 -> pc_en=0, fetch_valid=0 for 4 cycles, then pc_en=1, fetch_cnt+=1.
REQ-034 SHALL test redirect under stall: stall=1, redirect_en=1, redirect_pc=0x200; then stall=0 two cycles later -> state PEND, pc_en=1, new_pc=0x200 on stall release, fetch_valid=0 that cycle.
REQ-035 SHALL test redirect overwrite: in PEND, redirect_pc=0x300 with stall=1, then stall=0 -> new_pc=0x300.
REQ-036 SHALL test halt vs redirect same cycle: halt=1, redirect_en=1, ihit=1 -> pc_en=0, halted=1 next cycle, imemREN=0, fetch_cnt frozen.
REQ-037 SHALL test reset from HALTED and from PEND: RST=1 one cycle -> halted=0, fetch_cnt=0, state RUN, imemREN=1 next cycle.
